// File: rtl/ov7670_pkg.sv
// Shared capture definitions: FSM encoding and RGB565 field layout.
package ov7670_pkg;

   typedef enum logic [1:0] {
      ST_SKIP     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_CAPTURE  = 2'd2
   } cap_state_t;

   // RGB565 field widths and bit positions, shared with the VGA colour expansion
   localparam int unsigned RGB_W = 16;
   localparam int unsigned R_W   = 5;
   localparam int unsigned G_W   = 6;
   localparam int unsigned B_W   = 5;
   localparam int unsigned R_LSB = 11;
   localparam int unsigned G_LSB = 5;
   localparam int unsigned B_LSB = 0;

   typedef struct packed {
      logic [R_W-1:0] r;
      logic [G_W-1:0] g;
      logic [B_W-1:0] b;
   } rgb565_t;

   // The camera sends the high byte first; split the pair into colour fields.
   function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
      logic [RGB_W-1:0] w;
      rgb565_t          p;
      w   = {hi, lo};
      p.r = w[R_LSB +: R_W];
      p.g = w[G_LSB +: G_W];
      p.b = w[B_LSB +: B_W];
      return p;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers a 1-bit input and flags its rising and falling edges.
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_sig,
   output logic o_level,
   output logic o_rise_c,
   output logic o_fall_c
);

   logic r_q;
   logic r_q_d;

   // Input sample plus one-cycle history for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q   <= 1'b0;
         r_q_d <= 1'b0;
      end else begin
         r_q   <= i_sig;
         r_q_d <= r_q;
      end
   end

   assign o_level  = r_q;
   assign o_rise_c = r_q & ~r_q_d;
   assign o_fall_c = ~r_q & r_q_d;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: pairs bytes into RGB565 words for the async FIFO.
module ov7670_capture
   import ov7670_pkg::*;
#(
   parameter int unsigned SKIP_FRAMES = 2,
   parameter int unsigned H_PIXELS    = 640,
   parameter int unsigned V_LINES     = 480
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cam_vsync,
   input  logic                           cam_href,
   input  logic [7:0]                     cam_data,
   input  logic                           fifo_full,
   output logic                           wr_en,
   output logic [15:0]                    dout,
   output logic                           frame_start,
   output logic                           frame_done,
   output logic [$clog2(V_LINES+1)-1:0]   line_cnt,
   output logic                           overflow,
   output logic                           frame_err
);

   localparam int unsigned PW = $clog2(H_PIXELS + 1);
   localparam int unsigned LW = $clog2(V_LINES + 1);
   localparam int unsigned SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
   localparam logic [PW-1:0] PIX_MAX  = '1;
   localparam logic [LW-1:0] LINE_MAX = '1;

   cap_state_t     r_state,    w_state_nxt;
   logic [SW-1:0]  r_skip_cnt, w_skip_nxt;
   logic [7:0]     r_hi,       w_hi_nxt;
   logic           r_phase,    w_phase_nxt;
   logic [PW-1:0]  r_pix_cnt,  w_pix_nxt;
   logic [LW-1:0]  r_line_cnt, w_line_nxt;
   rgb565_t        r_dout,     w_dout_nxt;
   logic           r_wr_en,    w_wr_nxt;
   logic           r_fstart,   w_fstart_nxt;
   logic           r_fdone,    w_fdone_nxt;
   logic           r_ovf,      w_ovf_nxt;
   logic           r_ferr,     w_ferr_nxt;
   logic [7:0]     r_data;
   logic           r_full;

   logic w_vs_level, w_vs_rise, w_vs_fall;
   logic w_hs_level, w_hs_rise_unused, w_hs_fall;
   logic w_href_ok;

   sync_edge_detect u_vsync (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_sig    (cam_vsync),
      .o_level  (w_vs_level),
      .o_rise_c (w_vs_rise),
      .o_fall_c (w_vs_fall)
   );

   sync_edge_detect u_href (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_sig    (cam_href),
      .o_level  (w_hs_level),
      .o_rise_c (w_hs_rise_unused),
      .o_fall_c (w_hs_fall)
   );

   // Bytes are only valid outside vertical blanking
   assign w_href_ok = w_hs_level & ~w_vs_level;

   // Next-state and datapath: skip start-up frames, then pair bytes per line
   always_comb begin
      w_state_nxt  = r_state;
      w_skip_nxt   = r_skip_cnt;
      w_hi_nxt     = r_hi;
      w_phase_nxt  = r_phase;
      w_pix_nxt    = r_pix_cnt;
      w_line_nxt   = r_line_cnt;
      w_dout_nxt   = r_dout;
      w_wr_nxt     = 1'b0;
      w_fstart_nxt = 1'b0;
      w_fdone_nxt  = 1'b0;
      w_ovf_nxt    = r_ovf;
      w_ferr_nxt   = r_ferr;

      case (r_state)
         ST_SKIP: begin
            if (SKIP_FRAMES == 0) begin
               w_state_nxt = ST_WAIT_SOF;
            end else if (w_vs_rise) begin
               w_skip_nxt = r_skip_cnt + SW'(1);
               if (w_skip_nxt == SW'(SKIP_FRAMES)) w_state_nxt = ST_WAIT_SOF;
            end
         end

         ST_WAIT_SOF: begin
            if (w_vs_fall) begin
               w_fstart_nxt = 1'b1;
               w_line_nxt   = '0;
               w_pix_nxt    = '0;
               w_phase_nxt  = 1'b0;
               w_state_nxt  = ST_CAPTURE;
            end
         end

         ST_CAPTURE: begin
            if (w_vs_rise) begin
               // End of frame wins over any byte in flight; a partial line is an error
               w_fdone_nxt = 1'b1;
               if ((r_line_cnt != LW'(V_LINES)) || w_hs_level || r_phase || (r_pix_cnt != '0))
                  w_ferr_nxt = 1'b1;
               w_state_nxt = ST_WAIT_SOF;
            end else begin
               if (w_href_ok) begin
                  w_phase_nxt = ~r_phase;
                  if (!r_phase) begin
                     w_hi_nxt = r_data;
                  end else begin
                     if (r_full) begin
                        w_ovf_nxt = 1'b1;
                     end else begin
                        w_wr_nxt   = 1'b1;
                        w_dout_nxt = pack_rgb565(r_hi, r_data);
                     end
                     if (r_pix_cnt != PIX_MAX) w_pix_nxt = r_pix_cnt + PW'(1);
                  end
               end
               if (w_hs_fall) begin
                  if (r_line_cnt != LINE_MAX) w_line_nxt = r_line_cnt + LW'(1);
                  if ((r_pix_cnt != PW'(H_PIXELS)) || r_phase) w_ferr_nxt = 1'b1;
                  w_pix_nxt   = '0;
                  w_phase_nxt = 1'b0;
               end
            end
         end

         default: w_state_nxt = ST_SKIP;
      endcase
   end

   // State, counters, input samples and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_SKIP;
         r_skip_cnt <= '0;
         r_hi       <= '0;
         r_phase    <= 1'b0;
         r_pix_cnt  <= '0;
         r_line_cnt <= '0;
         r_dout     <= '0;
         r_wr_en    <= 1'b0;
         r_fstart   <= 1'b0;
         r_fdone    <= 1'b0;
         r_ovf      <= 1'b0;
         r_ferr     <= 1'b0;
         r_data     <= '0;
         r_full     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_skip_cnt <= w_skip_nxt;
         r_hi       <= w_hi_nxt;
         r_phase    <= w_phase_nxt;
         r_pix_cnt  <= w_pix_nxt;
         r_line_cnt <= w_line_nxt;
         r_dout     <= w_dout_nxt;
         r_wr_en    <= w_wr_nxt;
         r_fstart   <= w_fstart_nxt;
         r_fdone    <= w_fdone_nxt;
         r_ovf      <= w_ovf_nxt;
         r_ferr     <= w_ferr_nxt;
         r_data     <= cam_data;
         r_full     <= fifo_full;
      end
   end

   assign wr_en       = r_wr_en;
   assign dout        = r_dout;
   assign frame_start = r_fstart;
   assign frame_done  = r_fdone;
   assign line_cnt    = r_line_cnt;
   assign overflow    = r_ovf;
   assign frame_err   = r_ferr;

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized bench for ov7670_capture against a frame/line level reference model.
module tb_ov7670_capture;

   localparam int unsigned SKIP = 2;
   localparam int unsigned HP   = 4;
   localparam int unsigned VL   = 2;
   localparam int unsigned LW   = $clog2(VL + 1);
   localparam int          LMAX = (1 << LW) - 1;

   logic          clk;
   logic          rst_n;
   logic          cam_vsync;
   logic          cam_href;
   logic [7:0]    cam_data;
   logic          fifo_full;
   logic          wr_en;
   logic [15:0]   dout;
   logic          frame_start;
   logic          frame_done;
   logic [LW-1:0] line_cnt;
   logic          overflow;
   logic          frame_err;

   ov7670_capture #(
      .SKIP_FRAMES (SKIP),
      .H_PIXELS    (HP),
      .V_LINES     (VL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_data    (cam_data),
      .fifo_full   (fifo_full),
      .wr_en       (wr_en),
      .dout        (dout),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .line_cnt    (line_cnt),
      .overflow    (overflow),
      .frame_err   (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] w;
      int          c;
   } exp_wr_t;

   exp_wr_t    exp_q[$];
   exp_wr_t    mon_e;
   logic [7:0] ln_b[$];
   bit         ln_f[$];
   logic [7:0] pat [0:7] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
   int         len_opts [0:6] = '{8, 8, 8, 6, 7, 10, 16};

   int n_checks  = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int n_start   = 0;
   int n_done    = 0;
   int exp_start = 0;
   int exp_done  = 0;
   int m_skipped = 0;
   int m_lines   = 0;
   bit m_cap     = 1'b0;
   bit m_ovf     = 1'b0;
   bit m_err     = 1'b0;
   bit prev_wr   = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: every write must match the next expected word and its cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_wr = 1'b0;
      end else begin
         if (frame_start) n_start++;
         if (frame_done)  n_done++;
         if (wr_en) begin
            check_eq("wr_gap", 32'(prev_wr), 32'd0);
            if (exp_q.size() == 0) begin
               check_eq("unexpected_wr", 32'(exp_q.size()), 32'd1);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("dout", 32'(dout), 32'(mon_e.w));
               check_eq("wr_cycle", 32'(cyc), 32'(mon_e.c));
            end
         end
         prev_wr = wr_en;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      #2 rst_n = 1'b0;
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      cam_data  = 8'h00;
      fifo_full = 1'b0;
      #1;
      check_eq("rst_wr_en",       32'(wr_en),       32'd0);
      check_eq("rst_dout",        32'(dout),        32'd0);
      check_eq("rst_frame_start", 32'(frame_start), 32'd0);
      check_eq("rst_frame_done",  32'(frame_done),  32'd0);
      check_eq("rst_line_cnt",    32'(line_cnt),    32'd0);
      check_eq("rst_overflow",    32'(overflow),    32'd0);
      check_eq("rst_frame_err",   32'(frame_err),   32'd0);
      m_skipped = 0;
      m_cap     = 1'b0;
      m_lines   = 0;
      m_ovf     = 1'b0;
      m_err     = 1'b0;
      exp_q.delete();
      idle(2);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic build_line(input int nbytes, input int full_pct);
      ln_b.delete();
      ln_f.delete();
      for (int i = 0; i < nbytes; i++) begin
         ln_b.push_back(8'($urandom));
         ln_f.push_back(int'($urandom_range(99)) < full_pct);
      end
   endtask

   // Drive the current line's bytes; every second byte completes an expected word
   task automatic drive_bytes();
      logic [7:0] hi;
      hi = 8'h00;
      for (int i = 0; i < ln_b.size(); i++) begin
         cam_href  = 1'b1;
         cam_data  = ln_b[i];
         fifo_full = ln_f[i];
         if (i % 2 == 0) begin
            hi = ln_b[i];
         end else if (m_cap) begin
            if (ln_f[i]) m_ovf = 1'b1;
            else         exp_q.push_back('{{hi, ln_b[i]}, cyc + 2});
         end
         @(negedge clk);
      end
   endtask

   task automatic send_line();
      int n;
      n = ln_b.size();
      drive_bytes();
      cam_href  = 1'b0;
      cam_data  = 8'h00;
      fifo_full = 1'b0;
      idle(3);
      if (m_cap) begin
         m_lines = (m_lines < LMAX) ? m_lines + 1 : LMAX;
         if ((n % 2 != 0) || (n / 2 != int'(HP))) m_err = 1'b1;
         check_eq("line_cnt", 32'(line_cnt), 32'(m_lines));
      end
      check_eq("overflow",   32'(overflow),     32'(m_ovf));
      check_eq("frame_err",  32'(frame_err),    32'(m_err));
      check_eq("pending_wr", 32'(exp_q.size()), 32'd0);
   endtask

   // vsync pulse between frames: ends a captured frame, then may start the next
   task automatic vsync_pulse();
      cam_vsync = 1'b1;
      idle(3);
      if (m_cap) begin
         exp_done++;
         if (m_lines != int'(VL)) m_err = 1'b1;
         m_cap = 1'b0;
         check_eq("eof_line_cnt", 32'(line_cnt), 32'(m_lines));
      end else if (m_skipped < int'(SKIP)) begin
         m_skipped++;
      end
      check_eq("frame_done_cnt", 32'(n_done),    32'(exp_done));
      check_eq("eof_frame_err",  32'(frame_err), 32'(m_err));
      cam_vsync = 1'b0;
      idle(3);
      if (!m_cap && m_skipped >= int'(SKIP)) begin
         m_cap   = 1'b1;
         m_lines = 0;
         exp_start++;
      end
      check_eq("frame_start_cnt", 32'(n_start), 32'(exp_start));
      if (m_cap) check_eq("sof_line_cnt", 32'(line_cnt), 32'd0);
   endtask

   task automatic random_frame(input int nlines, input int full_pct);
      for (int l = 0; l < nlines; l++) begin
         build_line(len_opts[$urandom_range(6)], full_pct);
         send_line();
      end
      vsync_pulse();
   endtask

   task automatic good_frame();
      for (int l = 0; l < int'(VL); l++) begin
         build_line(2 * int'(HP), 0);
         send_line();
      end
      vsync_pulse();
   endtask

   task automatic skip_frames();
      repeat (SKIP) good_frame();
   endtask

   initial begin
      rst_n     = 1'b1;
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      cam_data  = 8'h00;
      fifo_full = 1'b0;
      #1 rst_n  = 1'b0;
      @(negedge clk);
      apply_reset();

      // Start-up frames are discarded; the following frame is captured
      skip_frames();
      check_eq("capturing_after_skip", 32'(n_start), 32'd1);

      // Known colour bars, then a second correct line
      build_line(8, 0);
      for (int i = 0; i < 8; i++) ln_b[i] = pat[i];
      send_line();
      build_line(8, 0);
      send_line();
      vsync_pulse();

      // FIFO full while the second word forms: word dropped, overflow sticky
      build_line(8, 0);
      ln_f[3] = 1'b1;
      send_line();
      build_line(8, 0);
      send_line();
      vsync_pulse();
      good_frame();

      // Three lines against V_LINES=2: frame error, line_cnt reads 3 at frame end
      for (int l = 0; l < 3; l++) begin
         build_line(8, 0);
         send_line();
      end
      vsync_pulse();

      // Odd byte count on a line after a clean reset
      apply_reset();
      skip_frames();
      build_line(7, 0);
      send_line();
      build_line(8, 0);
      send_line();
      vsync_pulse();

      // Reset mid-line after three bytes, then the skip count applies again
      build_line(3, 0);
      drive_bytes();
      apply_reset();
      skip_frames();
      random_frame(2, 0);

      // Randomized frames: length, byte count, data and FIFO back-pressure
      repeat (3) begin
         apply_reset();
         skip_frames();
         repeat (3) random_frame(int'($urandom_range(1, 4)), 15);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
